tlb_param: RTL and testbench

TLB_PARAM -- requirements
Module: tlb_param

---
 rtl/tlb_pkg.sv | 44 ++++
 rtl/tlb_lookup.sv | 86 ++++++++
 rtl/tlb_param.sv | 256 +++++++++++++++++++++++++
 tb/tb_tlb_param.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB types, page-size constants, INVTLB op encodings and the VA match helper.
`default_nettype none

package tlb_pkg;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  typedef enum logic [4:0] {
    INV_ALL        = 5'd0,
    INV_ALL_ALT    = 5'd1,
    INV_G          = 5'd2,
    INV_NG         = 5'd3,
    INV_NG_ASID    = 5'd4,
    INV_NG_ASID_VA = 5'd5,
    INV_GASID_VA   = 5'd6
  } inv_op_e;

  // E lives outside the struct so that only it needs a reset.
  typedef struct packed {
    logic [18:0] vppn;
    logic        ps4m;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } tlb_entry_t;

  // 4MB pages ignore vppn[8:0].
  function automatic logic va_match(input tlb_entry_t ent, input logic [18:0] vppn);
    return (ent.vppn[18:9] == vppn[18:9]) && (ent.ps4m || (ent.vppn[8:0] == vppn[8:0]));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlb_lookup.sv
// One search port: associative compare, lowest-index priority select and odd/even page pick.
`default_nettype none

module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic [TLBNUM-1:0]      e,
  input  tlb_entry_t [TLBNUM-1:0] ents,
  input  logic [18:0]            vppn,
  input  logic                   va_bit12,
  input  logic [9:0]             asid,
  output logic                   found,
  output logic [IDXW-1:0]        index,
  output logic [19:0]            ppn,
  output logic [5:0]             ps,
  output logic [1:0]             plv,
  output logic [1:0]             mat,
  output logic                   d,
  output logic                   v
);

  logic        sel_ps4m;
  logic [19:0] sel_ppn0, sel_ppn1;
  logic [1:0]  sel_plv0, sel_plv1, sel_mat0, sel_mat1;
  logic        sel_d0, sel_d1, sel_v0, sel_v1;
  logic        odd;

  always_comb begin
    found    = 1'b0;
    index    = '0;
    sel_ps4m = 1'b0;
    sel_ppn0 = '0;
    sel_ppn1 = '0;
    sel_plv0 = '0;
    sel_plv1 = '0;
    sel_mat0 = '0;
    sel_mat1 = '0;
    sel_d0   = 1'b0;
    sel_d1   = 1'b0;
    sel_v0   = 1'b0;
    sel_v1   = 1'b0;
    // Descending scan: the last hit written is the lowest matching index.
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (e[i] && va_match(ents[i], vppn) && (ents[i].g || (ents[i].asid == asid))) begin
        found    = 1'b1;
        index    = IDXW'(i);
        sel_ps4m = ents[i].ps4m;
        sel_ppn0 = ents[i].ppn0;
        sel_ppn1 = ents[i].ppn1;
        sel_plv0 = ents[i].plv0;
        sel_plv1 = ents[i].plv1;
        sel_mat0 = ents[i].mat0;
        sel_mat1 = ents[i].mat1;
        sel_d0   = ents[i].d0;
        sel_d1   = ents[i].d1;
        sel_v0   = ents[i].v0;
        sel_v1   = ents[i].v1;
      end
    end
  end

  assign odd = sel_ps4m ? vppn[8] : va_bit12;

  always_comb begin
    ppn = '0;
    ps  = '0;
    plv = '0;
    mat = '0;
    d   = 1'b0;
    v   = 1'b0;
    if (found) begin
      ppn = odd ? sel_ppn1 : sel_ppn0;
      ps  = sel_ps4m ? PS_4M : PS_4K;
      plv = odd ? sel_plv1 : sel_plv0;
      mat = odd ? sel_mat1 : sel_mat0;
      d   = odd ? sel_d1 : sel_d0;
      v   = odd ? sel_v1 : sel_v0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlb_param.sv
// Parameterised multi-port LoongArch-style TLB with INVTLB, TLBFILL index and read port.
// Optional build macro TLB_PERF_CNT_EN adds saturating per-port hit/miss counters.
`default_nettype none

module tlb_param
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int NPORT  = 2,
  localparam int IDXW  = $clog2(TLBNUM)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      s_req,
  input  logic [NPORT*19-1:0]   s_vppn,
  input  logic [NPORT-1:0]      s_va_bit12,
  input  logic [NPORT*10-1:0]   s_asid,
  output logic [NPORT-1:0]      s_rvalid,
  output logic [NPORT-1:0]      s_found,
  output logic [NPORT*IDXW-1:0] s_index,
  output logic [NPORT*20-1:0]   s_ppn,
  output logic [NPORT*6-1:0]    s_ps,
  output logic [NPORT*2-1:0]    s_plv,
  output logic [NPORT*2-1:0]    s_mat,
  output logic [NPORT-1:0]      s_d,
  output logic [NPORT-1:0]      s_v,
  input  logic                  inv_valid,
  input  logic [4:0]            inv_op,
  input  logic [9:0]            inv_asid,
  input  logic [18:0]           inv_vppn,
  output logic                  inv_err,
  input  logic                  we,
  input  logic                  w_fill,
  input  logic [IDXW-1:0]       w_index,
  input  logic                  w_e,
  input  logic [18:0]           w_vppn,
  input  logic [5:0]            w_ps,
  input  logic [9:0]            w_asid,
  input  logic                  w_g,
  input  logic [19:0]           w_ppn0,
  input  logic [19:0]           w_ppn1,
  input  logic [1:0]            w_plv0,
  input  logic [1:0]            w_plv1,
  input  logic [1:0]            w_mat0,
  input  logic [1:0]            w_mat1,
  input  logic                  w_d0,
  input  logic                  w_d1,
  input  logic                  w_v0,
  input  logic                  w_v1,
  input  logic [IDXW-1:0]       r_index,
  output logic                  r_e,
  output logic [18:0]           r_vppn,
  output logic [5:0]            r_ps,
  output logic [9:0]            r_asid,
  output logic                  r_g,
  output logic [19:0]           r_ppn0,
  output logic [19:0]           r_ppn1,
  output logic [1:0]            r_plv0,
  output logic [1:0]            r_plv1,
  output logic [1:0]            r_mat0,
  output logic [1:0]            r_mat1,
  output logic                  r_d0,
  output logic                  r_d1,
  output logic                  r_v0,
  output logic                  r_v1,
  output logic [IDXW-1:0]       fill_index,
  output logic [NPORT*32-1:0]   hit_cnt,
  output logic [NPORT*32-1:0]   miss_cnt
);

  logic [TLBNUM-1:0]      e_q;
  tlb_entry_t [TLBNUM-1:0] ent_q;
  tlb_entry_t             w_ent;
  logic [IDXW-1:0]        fill_q;
  logic [IDXW-1:0]        widx;
  logic [TLBNUM-1:0]      inv_hit;
  logic                   inv_err_q;

  assign widx = w_fill ? fill_q : w_index;

  always_comb begin
    w_ent.vppn = w_vppn;
    w_ent.ps4m = (w_ps == PS_4M);
    w_ent.asid = w_asid;
    w_ent.g    = w_g;
    w_ent.ppn0 = w_ppn0;
    w_ent.ppn1 = w_ppn1;
    w_ent.plv0 = w_plv0;
    w_ent.plv1 = w_plv1;
    w_ent.mat0 = w_mat0;
    w_ent.mat1 = w_mat1;
    w_ent.d0   = w_d0;
    w_ent.d1   = w_d1;
    w_ent.v0   = w_v0;
    w_ent.v1   = w_v1;
  end

  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        INV_ALL, INV_ALL_ALT: inv_hit[i] = 1'b1;
        INV_G:                inv_hit[i] = ent_q[i].g;
        INV_NG:               inv_hit[i] = !ent_q[i].g;
        INV_NG_ASID:          inv_hit[i] = !ent_q[i].g && (ent_q[i].asid == inv_asid);
        INV_NG_ASID_VA:       inv_hit[i] = !ent_q[i].g && (ent_q[i].asid == inv_asid)
                                           && va_match(ent_q[i], inv_vppn);
        INV_GASID_VA:         inv_hit[i] = (ent_q[i].g || (ent_q[i].asid == inv_asid))
                                           && va_match(ent_q[i], inv_vppn);
        default:              inv_hit[i] = 1'b0;
      endcase
    end
  end

  // A same-cycle write owns its index; INVTLB only touches the others.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && (widx == IDXW'(i))) begin
          e_q[i] <= w_e;
        end else if (inv_valid && inv_hit[i]) begin
          e_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      ent_q[widx] <= w_ent;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_q    <= '0;
      inv_err_q <= 1'b0;
    end else begin
      if (we && w_fill) begin
        fill_q <= fill_q + 1'b1;
      end
      inv_err_q <= inv_valid && (inv_op >= 5'd7);
    end
  end

  assign fill_index = fill_q;
  assign inv_err    = inv_err_q;

  assign r_e    = e_q[r_index];
  assign r_vppn = ent_q[r_index].vppn;
  assign r_ps   = ent_q[r_index].ps4m ? PS_4M : PS_4K;
  assign r_asid = ent_q[r_index].asid;
  assign r_g    = ent_q[r_index].g;
  assign r_ppn0 = ent_q[r_index].ppn0;
  assign r_ppn1 = ent_q[r_index].ppn1;
  assign r_plv0 = ent_q[r_index].plv0;
  assign r_plv1 = ent_q[r_index].plv1;
  assign r_mat0 = ent_q[r_index].mat0;
  assign r_mat1 = ent_q[r_index].mat1;
  assign r_d0   = ent_q[r_index].d0;
  assign r_d1   = ent_q[r_index].d1;
  assign r_v0   = ent_q[r_index].v0;
  assign r_v1   = ent_q[r_index].v1;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic            hit;
    logic [IDXW-1:0] idx;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv, mat;
    logic            d, v;
    logic            rv_q, found_q, d_q, v_q;
    logic [IDXW-1:0] idx_q;
    logic [19:0]     ppn_q;
    logic [5:0]      ps_q;
    logic [1:0]      plv_q, mat_q;

    tlb_lookup #(.TLBNUM(TLBNUM)) u_lookup (
      .e        (e_q),
      .ents     (ent_q),
      .vppn     (s_vppn[p*19 +: 19]),
      .va_bit12 (s_va_bit12[p]),
      .asid     (s_asid[p*10 +: 10]),
      .found    (hit),
      .index    (idx),
      .ppn      (ppn),
      .ps       (ps),
      .plv      (plv),
      .mat      (mat),
      .d        (d),
      .v        (v)
    );

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rv_q    <= 1'b0;
        found_q <= 1'b0;
        idx_q   <= '0;
        ppn_q   <= '0;
        ps_q    <= '0;
        plv_q   <= '0;
        mat_q   <= '0;
        d_q     <= 1'b0;
        v_q     <= 1'b0;
      end else begin
        rv_q    <= s_req[p];
        found_q <= s_req[p] && hit;
        idx_q   <= idx;
        ppn_q   <= ppn;
        ps_q    <= ps;
        plv_q   <= plv;
        mat_q   <= mat;
        d_q     <= d;
        v_q     <= v;
      end
    end

    assign s_rvalid[p]            = rv_q;
    assign s_found[p]             = found_q;
    assign s_index[p*IDXW +: IDXW] = idx_q;
    assign s_ppn[p*20 +: 20]      = ppn_q;
    assign s_ps[p*6 +: 6]         = ps_q;
    assign s_plv[p*2 +: 2]        = plv_q;
    assign s_mat[p*2 +: 2]        = mat_q;
    assign s_d[p]                 = d_q;
    assign s_v[p]                 = v_q;

`ifdef TLB_PERF_CNT_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        hit_q  <= '0;
        miss_q <= '0;
      end else if (rv_q) begin
        if (found_q) begin
          if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
        end else begin
          if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
        end
      end
    end

    assign hit_cnt[p*32 +: 32]  = hit_q;
    assign miss_cnt[p*32 +: 32] = miss_q;
`else
    assign hit_cnt[p*32 +: 32]  = '0;
    assign miss_cnt[p*32 +: 32] = '0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_tlb_param.sv
// Directed scoreboard bench for tlb_param (16-entry main instance plus a 4-entry fill instance).
`default_nettype none

module tb_tlb_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [1:0]  s_req, s_va_bit12;
  logic [37:0] s_vppn;
  logic [19:0] s_asid;
  logic        inv_valid;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic        we, w_fill, w_e, w_g, w_d0, w_d1, w_v0, w_v1;
  logic [3:0]  w_index, r_index;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1;

  // main instance outputs
  logic [1:0]  s_rvalid, s_found, s_d, s_v;
  logic [7:0]  s_index;
  logic [39:0] s_ppn;
  logic [11:0] s_ps;
  logic [3:0]  s_plv, s_mat;
  logic        inv_err, r_e, r_g, r_d0, r_d1, r_v0, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;
  logic [3:0]  fill_index;
  logic [63:0] hit_cnt, miss_cnt;

  // 4-entry instance outputs
  logic [1:0]  b_rvalid, b_found, b_d, b_v;
  logic [3:0]  b_index;
  logic [39:0] b_ppn;
  logic [11:0] b_ps;
  logic [3:0]  b_plv, b_mat;
  logic        b_inv_err, b_r_e, b_r_g, b_r_d0, b_r_d1, b_r_v0, b_r_v1;
  logic [18:0] b_r_vppn;
  logic [5:0]  b_r_ps;
  logic [9:0]  b_r_asid;
  logic [19:0] b_r_ppn0, b_r_ppn1;
  logic [1:0]  b_r_plv0, b_r_plv1, b_r_mat0, b_r_mat1;
  logic [1:0]  b_fill_index;
  logic [63:0] b_hit_cnt, b_miss_cnt;

  tlb_param #(.TLBNUM(16), .NPORT(2)) dut (
    .clk(clk), .resetn(resetn), .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12),
    .s_asid(s_asid), .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn),
    .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_err(inv_err), .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e),
    .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0),
    .w_ppn1(w_ppn1), .w_plv0(w_plv0), .w_plv1(w_plv1), .w_mat0(w_mat0), .w_mat1(w_mat1),
    .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1), .r_index(r_index), .r_e(r_e),
    .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g), .r_ppn0(r_ppn0),
    .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1), .r_mat0(r_mat0), .r_mat1(r_mat1),
    .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1), .fill_index(fill_index),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  tlb_param #(.TLBNUM(4), .NPORT(2)) dut4 (
    .clk(clk), .resetn(resetn), .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12),
    .s_asid(s_asid), .s_rvalid(b_rvalid), .s_found(b_found), .s_index(b_index), .s_ppn(b_ppn),
    .s_ps(b_ps), .s_plv(b_plv), .s_mat(b_mat), .s_d(b_d), .s_v(b_v),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_err(b_inv_err), .we(we), .w_fill(w_fill), .w_index(w_index[1:0]), .w_e(w_e),
    .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0),
    .w_ppn1(w_ppn1), .w_plv0(w_plv0), .w_plv1(w_plv1), .w_mat0(w_mat0), .w_mat1(w_mat1),
    .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1), .r_index(r_index[1:0]), .r_e(b_r_e),
    .r_vppn(b_r_vppn), .r_ps(b_r_ps), .r_asid(b_r_asid), .r_g(b_r_g), .r_ppn0(b_r_ppn0),
    .r_ppn1(b_r_ppn1), .r_plv0(b_r_plv0), .r_plv1(b_r_plv1), .r_mat0(b_r_mat0),
    .r_mat1(b_r_mat1), .r_d0(b_r_d0), .r_d1(b_r_d1), .r_v0(b_r_v0), .r_v1(b_r_v1),
    .fill_index(b_fill_index), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
  );

  typedef struct {
    int          port;
    logic        found;
    logic [3:0]  idx;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned hit_m[2];
  int unsigned miss_m[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_req     = '0;
    we        = 1'b0;
    w_fill    = 1'b0;
    inv_valid = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [18:0] vppn, input logic [9:0] asid,
                             input logic g, input logic [5:0] ps, input logic [19:0] p0,
                             input logic [19:0] p1, input logic v0, input logic v1);
    we = 1'b1; w_fill = 1'b0; w_index = idx; w_e = 1'b1; w_vppn = vppn; w_asid = asid;
    w_g = g; w_ps = ps; w_ppn0 = p0; w_ppn1 = p1; w_v0 = v0; w_v1 = v1;
    w_plv0 = 2'd2; w_plv1 = 2'd1; w_mat0 = 2'd1; w_mat1 = 2'd0; w_d0 = 1'b1; w_d1 = 1'b0;
  endtask

  task automatic lookup(input int p, input logic [18:0] vppn, input logic b12, input logic [9:0] asid,
                        input logic f, input logic [3:0] idx, input logic [19:0] ppn,
                        input logic [5:0] ps, input logic v);
    exp_t x;
    s_req[p] = 1'b1;
    s_vppn[p*19 +: 19] = vppn;
    s_va_bit12[p] = b12;
    s_asid[p*10 +: 10] = asid;
    x.port = p; x.found = f; x.idx = idx; x.ppn = ppn; x.ps = ps; x.v = v;
    sb.push_back(x);
  endtask

  task automatic check_pending();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk($sformatf("rvalid%0d", x.port), 32'(s_rvalid[x.port]), 32'd1);
      chk($sformatf("found%0d", x.port), 32'(s_found[x.port]), 32'(x.found));
      chk($sformatf("index%0d", x.port), 32'(s_index[x.port*4 +: 4]), 32'(x.idx));
      chk($sformatf("ppn%0d", x.port), 32'(s_ppn[x.port*20 +: 20]), 32'(x.ppn));
      chk($sformatf("ps%0d", x.port), 32'(s_ps[x.port*6 +: 6]), 32'(x.ps));
      chk($sformatf("v%0d", x.port), 32'(s_v[x.port]), 32'(x.v));
      if (x.found) hit_m[x.port]++;
      else         miss_m[x.port]++;
    end
  endtask

  task automatic check_counters();
    for (int p = 0; p < 2; p++) begin
`ifdef TLB_PERF_CNT_EN
      chk($sformatf("hit_cnt%0d", p), hit_cnt[p*32 +: 32], hit_m[p]);
      chk($sformatf("miss_cnt%0d", p), miss_cnt[p*32 +: 32], miss_m[p]);
`else
      chk($sformatf("hit_cnt%0d", p), hit_cnt[p*32 +: 32], 32'd0);
      chk($sformatf("miss_cnt%0d", p), miss_cnt[p*32 +: 32], 32'd0);
`endif
    end
  endtask

  initial begin
    resetn = 1'b0;
    s_req = '0; s_vppn = '0; s_va_bit12 = '0; s_asid = '0;
    inv_valid = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
    we = 1'b0; w_fill = 1'b0; w_index = '0; w_e = 1'b0; w_vppn = '0; w_ps = '0; w_asid = '0;
    w_g = 1'b0; w_ppn0 = '0; w_ppn1 = '0; w_plv0 = '0; w_plv1 = '0; w_mat0 = '0; w_mat1 = '0;
    w_d0 = 1'b0; w_d1 = 1'b0; w_v0 = 1'b0; w_v1 = 1'b0; r_index = 4'd3;
    hit_m = '{0, 0}; miss_m = '{0, 0};

    // reset state
    tick(); tick();
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_found", 32'(s_found), 32'd0);
    chk("rst_inv_err", 32'(inv_err), 32'd0);
    chk("rst_fill", 32'(fill_index), 32'd0);
    chk("rst_r_e", 32'(r_e), 32'd0);
    check_counters();
    #2 resetn = 1'b1;

    // 4KB entry at idx3, even and odd halves
    tick();
    write_entry(4'd3, 19'h12345, 10'd5, 1'b0, 6'd12, 20'hAAAAA, 20'hBBBBB, 1'b1, 1'b0);
    tick();
    clear_inputs();
    lookup(0, 19'h12345, 1'b0, 10'd5, 1'b1, 4'd3, 20'hAAAAA, 6'd12, 1'b1);
    lookup(1, 19'h12345, 1'b1, 10'd5, 1'b1, 4'd3, 20'hBBBBB, 6'd12, 1'b0);
    tick();
    clear_inputs();
    check_pending();
    chk("plv0", 32'(s_plv[1:0]), 32'd2);
    chk("d0", 32'(s_d[0]), 32'd1);
    tick();
    chk("rvalid_idle", 32'(s_rvalid), 32'd0);

    // misses: wrong asid, wrong low vppn bits
    lookup(0, 19'h12345, 1'b0, 10'd6, 1'b0, 4'd0, 20'h0, 6'd0, 1'b0);
    lookup(1, 19'h12344, 1'b0, 10'd5, 1'b0, 4'd0, 20'h0, 6'd0, 1'b0);
    tick();
    clear_inputs();
    check_pending();

    // two global 4MB entries: lowest index wins, vppn[8] picks the half
    write_entry(4'd0, 19'h00400, 10'd0, 1'b1, 6'd21, 20'h11111, 20'h22222, 1'b1, 1'b1);
    tick();
    write_entry(4'd7, 19'h00400, 10'd0, 1'b1, 6'd21, 20'h11111, 20'h77777, 1'b1, 1'b1);
    tick();
    clear_inputs();
    lookup(0, 19'h00500, 1'b0, 10'd9, 1'b1, 4'd0, 20'h22222, 6'd21, 1'b1);
    lookup(1, 19'h00400, 1'b1, 10'd3, 1'b1, 4'd0, 20'h11111, 6'd21, 1'b1);
    tick();
    clear_inputs();
    check_pending();

    // write + INVTLB op5 + lookup in one cycle
    write_entry(4'd5, 19'h12345, 10'd5, 1'b0, 6'd12, 20'h55555, 20'h0, 1'b1, 1'b0);
    tick();
    write_entry(4'd3, 19'h12345, 10'd5, 1'b0, 6'd12, 20'hCCCCC, 20'hDDDDD, 1'b1, 1'b1);
    inv_valid = 1'b1; inv_op = 5'd5; inv_asid = 10'd5; inv_vppn = 19'h12345;
    lookup(0, 19'h12345, 1'b0, 10'd5, 1'b1, 4'd3, 20'hAAAAA, 6'd12, 1'b1);
    tick();
    clear_inputs();
    check_pending();
    r_index = 4'd3; #1;
    chk("inv5_idx3_e", 32'(r_e), 32'd1);
    chk("inv5_idx3_ppn0", 32'(r_ppn0), 32'hCCCCC);
    r_index = 4'd5; #1;
    chk("inv5_idx5_e", 32'(r_e), 32'd0);
    r_index = 4'd0; #1;
    chk("inv5_idx0_e", 32'(r_e), 32'd1);
    chk("inv5_idx0_ps", 32'(r_ps), 32'd21);
    lookup(1, 19'h12345, 1'b1, 10'd5, 1'b1, 4'd3, 20'hDDDDD, 6'd12, 1'b1);
    tick();
    clear_inputs();
    check_pending();

    // illegal op: one-cycle inv_err, entries untouched
    inv_valid = 1'b1; inv_op = 5'd9; inv_asid = 10'd0; inv_vppn = 19'h0;
    tick();
    clear_inputs();
    chk("inv_err_pulse", 32'(inv_err), 32'd1);
    tick();
    chk("inv_err_drop", 32'(inv_err), 32'd0);
    r_index = 4'd3; #1;
    chk("inv9_idx3_e", 32'(r_e), 32'd1);
    r_index = 4'd7; #1;
    chk("inv9_idx7_e", 32'(r_e), 32'd1);

    // op3 clears non-global only
    tick();
    inv_valid = 1'b1; inv_op = 5'd3;
    tick();
    clear_inputs();
    lookup(0, 19'h12345, 1'b0, 10'd5, 1'b0, 4'd0, 20'h0, 6'd0, 1'b0);
    lookup(1, 19'h00400, 1'b0, 10'd1, 1'b1, 4'd0, 20'h11111, 6'd21, 1'b1);
    tick();
    clear_inputs();
    check_pending();
    tick();
    check_counters();

    // reset during an in-flight lookup
    lookup(0, 19'h00400, 1'b0, 10'd1, 1'b1, 4'd0, 20'h11111, 6'd21, 1'b1);
    void'(sb.pop_back());
    tick();
    #2 resetn = 1'b0;
    clear_inputs();
    #1;
    chk("rst_async_rvalid", 32'(s_rvalid), 32'd0);
    r_index = 4'd0; #1;
    chk("rst_async_r_e", 32'(r_e), 32'd0);
    chk("rst_async_hit", hit_cnt[31:0], 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    tick();
    chk("rst_release_rvalid", 32'(s_rvalid), 32'd0);
    hit_m = '{0, 0}; miss_m = '{0, 0};

    // TLBFILL on the 4-entry instance: 0,1,2,3 then wrap
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill4_%0d", i), 32'(b_fill_index), 32'(i));
      write_entry(4'hF, 19'h00100 + 19'(i), 10'd1, 1'b0, 6'd12, 20'(i), 20'h0, 1'b1, 1'b0);
      w_fill = 1'b1;
      tick();
    end
    clear_inputs();
    chk("fill4_wrap", 32'(b_fill_index), 32'd0);
    chk("fill16_after4", 32'(fill_index), 32'd4);
    for (int k = 0; k < 4; k++) begin
      r_index = 4'(k); #1;
      chk($sformatf("fill4_e%0d", k), 32'(b_r_e), 32'd1);
      chk($sformatf("fill4_vppn%0d", k), 32'(b_r_vppn), 32'h100 + 32'(k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
